// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage plus the IF/ID buffer feeding the decode stage.
//   Generates sequential word-aligned PCs and issues them to instruction memory
//   over a req/gnt handshake. In-order responses (rvalid/rdata) fill a
//   DEPTH-entry buffer. The head entry is presented to decode as
//   {pc_o, inst_o, valid_o}. Decode can stall. The branch/jump logic can
//   redirect fetch, which flushes the buffer and drops responses still in
//   flight.
//
// Optional feature macro: FETCH_PERF_EN
//   Defined   : adds perf_fetch_o (dequeue count) and perf_flush_o (redirect
//               cycle count). Both are 32-bit wrapping counters cleared by reset.
//   Undefined : those ports and counters do not exist.
//
// Parameters
//   ADDR_LEN  PC / memory address width
//   INST_LEN  instruction width
//   RESET_PC  first fetch address after reset
//   DEPTH     buffer entries and maximum in-flight requests (power of 2, >= 2)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   stall_i        decode cannot accept the presented instruction
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target (low two bits forced to zero)
//   imem_req_o     request valid
//   imem_addr_o    request address (word aligned)
//   imem_gnt_i     request accepted (req & gnt = issue)
//   imem_rvalid_i  response valid (in order, at least one cycle after issue)
//   imem_rdata_i   response instruction
//   pc_o           PC of the presented instruction (holds while !valid_o)
//   inst_o         presented instruction (NOP while !valid_o)
//   valid_o        pc_o/inst_o valid
//   perf_fetch_o   (FETCH_PERF_EN) dequeued instruction count
//   perf_flush_o   (FETCH_PERF_EN) redirect cycle count
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  ADDR_LEN = 32,
  parameter int                  INST_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [ADDR_LEN-1:0] redirect_pc_i,
  output logic                imem_req_o,
  output logic [ADDR_LEN-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [INST_LEN-1:0] imem_rdata_i,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [INST_LEN-1:0] inst_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]         perf_fetch_o,
  output logic [31:0]         perf_flush_o,
`endif
  output logic                valid_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the occupancy counters can hold the value DEPTH itself
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ZERO = '0;
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
  localparam logic [INST_LEN-1:0] NOP_INST = INST_LEN'(32'h0000_0013);
  localparam logic [ADDR_LEN-1:0] PC_STEP  = ADDR_LEN'(32'd4);
  localparam logic [ADDR_LEN-1:0] ALIGN_M  = ~(ADDR_LEN'(32'd3));

  // Fetch address and buffer bookkeeping
  logic [ADDR_LEN-1:0] r_fetch_pc;
  logic [PTR_W-1:0]    r_alloc_ptr;
  logic [PTR_W-1:0]    r_fill_ptr;
  logic [PTR_W-1:0]    r_head_ptr;
  logic [CNT_W-1:0]    r_count;        // allocated entries
  logic [CNT_W-1:0]    r_outstanding;  // issued requests not yet answered
  logic [CNT_W-1:0]    r_drop;         // responses still to discard after a redirect
  logic [ADDR_LEN-1:0] r_pc_hold;      // last presented PC, shown while !valid_o

  // Buffer storage
  logic [ADDR_LEN-1:0] r_entry_pc   [DEPTH];
  logic [INST_LEN-1:0] r_entry_inst [DEPTH];
  logic [DEPTH-1:0]    r_entry_filled;

  logic                w_can_issue;
  logic                w_req;
  logic                w_issue;
  logic                w_rsp;
  logic                w_rsp_keep;
  logic                w_valid;
  logic                w_deq;
  logic [ADDR_LEN-1:0] w_redirect_pc;
  logic [ADDR_LEN-1:0] w_pc_out;
  logic [INST_LEN-1:0] w_inst_out;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [CNT_W-1:0]    w_outstanding_nxt;
  logic [CNT_W-1:0]    w_drop_nxt;

  // Request gating: the outstanding limit guards against overrunning the
  // buffer with responses that belong to flushed entries. Requests are masked
  // while reset is asserted.
  assign w_can_issue   = (r_count < DEPTH_C) && (r_outstanding < DEPTH_C);
  assign w_req         = reset && !redirect_i && w_can_issue;
  assign w_issue       = w_req && imem_gnt_i;

  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign w_rsp         = imem_rvalid_i && (r_outstanding != CNT_ZERO);
  // A response is written only if it is not being discarded. Data that
  // arrives in a redirect cycle belongs to a flushed entry.
  assign w_rsp_keep    = w_rsp && (r_drop == CNT_ZERO) && !redirect_i;

  assign w_valid       = r_entry_filled[r_head_ptr] && !redirect_i;
  assign w_deq         = w_valid && !stall_i;
  assign w_redirect_pc = redirect_pc_i & ALIGN_M;

  // Output mux: the data comes only from buffer registers, so there is no path from imem_rdata_i
  always_comb begin
    w_pc_out   = r_pc_hold;
    w_inst_out = NOP_INST;
    if (w_valid) begin
      w_pc_out   = r_entry_pc[r_head_ptr];
      w_inst_out = r_entry_inst[r_head_ptr];
    end else begin
      w_pc_out   = r_pc_hold;
      w_inst_out = NOP_INST;
    end
  end

  // Next-state values for the occupancy and drop counters
  always_comb begin
    w_count_nxt       = r_count + CNT_W'(w_issue) - CNT_W'(w_deq);
    w_outstanding_nxt = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_rsp);
    w_drop_nxt        = r_drop;
    if (redirect_i) begin
      // Everything still in flight after this cycle has to be thrown away
      w_count_nxt       = CNT_ZERO;
      w_outstanding_nxt = r_outstanding - CNT_W'(w_rsp);
      w_drop_nxt        = r_outstanding - CNT_W'(w_rsp);
    end else if (w_rsp && (r_drop != CNT_ZERO)) begin
      w_drop_nxt        = r_drop - CNT_W'(1'b1);
    end else begin
      w_drop_nxt        = r_drop;
    end
  end

  // Fetch PC, pointers and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_head_ptr    <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
      if (redirect_i) begin
        r_fetch_pc  <= w_redirect_pc;
        r_alloc_ptr <= '0;
        r_fill_ptr  <= '0;
        r_head_ptr  <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc  <= r_fetch_pc + PC_STEP;
          r_alloc_ptr <= r_alloc_ptr + PTR_ONE;
        end
        if (w_rsp_keep) begin
          r_fill_ptr <= r_fill_ptr + PTR_ONE;
        end
        if (w_deq) begin
          r_head_ptr <= r_head_ptr + PTR_ONE;
        end
      end
    end
  end

  // Buffer entries: allocate on issue, fill on response, free on dequeue.
  // Alloc and head can only coincide when the buffer is empty or full, so an
  // issue and a dequeue never target the same entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entry_pc[i]   <= '0;
        r_entry_inst[i] <= '0;
      end
    end else if (redirect_i) begin
      r_entry_filled <= '0;
    end else begin
      if (w_issue) begin
        r_entry_pc[r_alloc_ptr]     <= r_fetch_pc;
        r_entry_filled[r_alloc_ptr] <= 1'b0;
      end
      if (w_rsp_keep) begin
        r_entry_inst[r_fill_ptr]   <= imem_rdata_i;
        r_entry_filled[r_fill_ptr] <= 1'b1;
      end
      if (w_deq) begin
        r_entry_filled[r_head_ptr] <= 1'b0;
      end
    end
  end

  // Remember the presented PC so pc_o holds while nothing valid is shown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_hold <= '0;
    end else begin
      r_pc_hold <= w_pc_out;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  // Wrapping counters for dequeued instructions and redirect cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetch <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (w_deq) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (redirect_i) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_flush_o = r_perf_flush;
`endif

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign valid_o     = w_valid;
  assign pc_o        = w_pc_out;
  assign inst_o      = w_inst_out;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage with default parameters (DEPTH=2).
//   A small memory model answers each granted request one cycle later with
//   instruction 0xA0000000 | address. Expected PCs, instructions and request
//   behaviour are worked out by hand for each step.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  // Memory model and bench state
  logic        rsp_en;
  logic        stray;
  logic [31:0] pend[$];
  logic [31:0] deq_pc[$];
  logic [31:0] deq_inst[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .pc_o          (pc),
    .inst_o        (inst),
`ifdef FETCH_PERF_EN
    .perf_fetch_o  (perf_fetch),
    .perf_flush_o  (perf_flush),
`endif
    .valid_o       (valid)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive this cycle's response, then let combinational outputs settle
  task automatic settle();
    if (stray) begin
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
    end else if (rsp_en && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = inst_of(pend.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    #1;
  endtask

  // Record issue and dequeue seen before the edge, then advance one cycle
  task automatic edge_step();
    if (imem_req && gnt) pend.push_back(imem_addr);
    if (valid && !stall) begin
      deq_pc.push_back(pc);
      deq_inst.push_back(inst);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pcs [8];
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h200, 32'h300};

    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; rsp_en = 1'b0; stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    settle();
    chk("rst_valid", valid, 0); chk("rst_pc", pc, 0); chk("rst_inst", inst, NOP);
    chk("rst_req", imem_req, 0); chk("rst_addr", imem_addr, 0);
    rst_n = 1'b1;

    // Stray rvalid with nothing outstanding must be ignored
    stray = 1'b1;
    settle(); chk("s1_req", imem_req, 1); chk("s1_addr", imem_addr, 0);
    edge_step(); stray = 1'b0;

    // Streaming with gnt=1 and one-cycle memory latency
    gnt = 1'b1; rsp_en = 1'b1;
    settle(); chk("stray_ignored", valid, 0); chk("s2_addr", imem_addr, 0); chk("s2_req", imem_req, 1);
    edge_step();
    settle(); chk("s3_addr", imem_addr, 32'h4); chk("s3_valid", valid, 0);
    edge_step();
    settle(); chk("s4_valid", valid, 1); chk("s4_pc", pc, 0); chk("s4_inst", inst, 32'hA000_0000);
    chk("full_no_req", imem_req, 0);
    edge_step();
    settle(); chk("s5_pc", pc, 32'h4); chk("s5_inst", inst, 32'hA000_0004); chk("s5_addr", imem_addr, 32'h8);
    edge_step();
    settle(); chk("s6_valid", valid, 0); chk("pc_hold", pc, 32'h4); chk("s6_nop", inst, NOP);
    chk("s6_addr", imem_addr, 32'hC);
    edge_step();

    // Five stall cycles: output held, no requests once both entries allocated
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("stall%0d_pc", i), pc, 32'h8);
      chk($sformatf("stall%0d_valid", i), valid, 1);
      chk($sformatf("stall%0d_req", i), imem_req, 0);
      edge_step();
    end
    stall = 1'b0;
    settle(); chk("s12_pc", pc, 32'h8); edge_step();
    settle(); chk("s13_pc", pc, 32'hC); chk("s13_inst", inst, 32'hA000_000C); chk("s13_addr", imem_addr, 32'h10);
    edge_step();

    // Two requests outstanding (0x10, 0x14), then redirect to 0x103
    rsp_en = 1'b0;
    settle(); chk("s14_addr", imem_addr, 32'h14); chk("s14_req", imem_req, 1); edge_step();
    redir = 1'b1; redir_pc = 32'h103;
    settle(); chk("redir_req", imem_req, 0); chk("redir_valid", valid, 0); edge_step();
    redir = 1'b0; rsp_en = 1'b1;
    settle(); chk("out_full_req", imem_req, 0); chk("redir_addr", imem_addr, 32'h100); chk("drop1_valid", valid, 0);
    edge_step();
    settle(); chk("drop2_valid", valid, 0); chk("s17_req", imem_req, 1); chk("s17_addr", imem_addr, 32'h100);
    edge_step();
    settle(); chk("s18_valid", valid, 0); chk("s18_addr", imem_addr, 32'h104); edge_step();
    settle(); chk("tgt_valid", valid, 1); chk("tgt_pc", pc, 32'h100); chk("tgt_inst", inst, 32'hA000_0100);
    edge_step();
    settle(); chk("s20_pc", pc, 32'h104); chk("s20_addr", imem_addr, 32'h108); edge_step();

    // Redirect in the same cycle as the response for 0x108
    redir = 1'b1; redir_pc = 32'h200;
    settle(); chk("s21_valid", valid, 0); chk("s21_req", imem_req, 0); edge_step();
    redir = 1'b0;
    settle(); chk("s22_req", imem_req, 1); chk("s22_addr", imem_addr, 32'h200); chk("s22_valid", valid, 0);
    edge_step();
    settle(); chk("s23_valid", valid, 0); chk("s23_addr", imem_addr, 32'h204); edge_step();
    settle(); chk("s24_pc", pc, 32'h200); chk("s24_inst", inst, 32'hA000_0200); edge_step();

    // Redirect masks a filled head entry (0x204 must never be dequeued)
    redir = 1'b1; redir_pc = 32'h300;
    settle(); chk("mask_valid", valid, 0); chk("mask_inst", inst, NOP); edge_step();
    redir = 1'b0;

    // gnt low for three cycles: request and address held stable
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("nogrant%0d_req", i), imem_req, 1);
      chk($sformatf("nogrant%0d_addr", i), imem_addr, 32'h300);
      chk($sformatf("nogrant%0d_valid", i), valid, 0);
      edge_step();
    end
    gnt = 1'b1;
    settle(); chk("s29_addr", imem_addr, 32'h300); edge_step();
    settle(); chk("s30_addr", imem_addr, 32'h304); edge_step();
    settle(); chk("s31_pc", pc, 32'h300); chk("s31_inst", inst, 32'hA000_0300); edge_step();

    // Dequeued stream: nothing lost, duplicated or leaked from a flush
    chk("deq_count", deq_pc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("deq%0d_pc", i), (i < deq_pc.size()) ? deq_pc[i] : 32'hFFFF_FFFF, exp_pcs[i]);
      chk($sformatf("deq%0d_inst", i), (i < deq_inst.size()) ? deq_inst[i] : 32'hFFFF_FFFF, inst_of(exp_pcs[i]));
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, 8);
    chk("perf_flush", perf_flush, 3);
`endif

    // Reset mid-stream clears everything immediately
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", valid, 0); chk("mrst_req", imem_req, 0); chk("mrst_addr", imem_addr, 0);
    chk("mrst_pc", pc, 0); chk("mrst_inst", inst, NOP);
`ifdef FETCH_PERF_EN
    chk("mrst_perf_fetch", perf_fetch, 0);
    chk("mrst_perf_flush", perf_flush, 0);
`endif
    pend.delete();
    gnt = 1'b0;
    rst_n = 1'b1;
    stray = 1'b1;
    settle(); chk("pr_req", imem_req, 1); chk("pr_addr", imem_addr, 0); edge_step();
    stray = 1'b0; gnt = 1'b1;
    settle(); chk("pr_stray_ignored", valid, 0); edge_step();
    settle(); chk("pr_addr2", imem_addr, 32'h4); edge_step();
    settle(); chk("pr_valid", valid, 1); chk("pr_pc", pc, 0); chk("pr_inst", inst, 32'hA000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
